// File: rtl/round_pkg.sv
// round_pkg: shared types and constants for the round controller.
// Holds the controller state enum, the counter mode encodings driven on
// ctrl, and the who encodings reported by the game and echoed on rsp_who.
package round_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_REPORT = 2'd3
    } round_state_t;

    localparam logic [1:0] MODE_UP1 = 2'b00;
    localparam logic [1:0] MODE_UP2 = 2'b01;
    localparam logic [1:0] MODE_DN1 = 2'b10;
    localparam logic [1:0] MODE_DN2 = 2'b11;

    localparam logic [1:0] WHO_NONE = 2'b00;
    localparam logic [1:0] WHO_WIN  = 2'b01;
    localparam logic [1:0] WHO_LOSE = 2'b10;

endpackage

// File: rtl/sat_counter8.sv
// sat_counter8: 8-bit event counter that sticks at 255.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset, clears the count
//   clr   in   synchronous clear (has priority over inc)
//   inc   in   count one event this cycle
//   count out  current count, 0..255
module sat_counter8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] count_r;

    // Count register: clear wins, increment stops at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 8'd0;
        end else if (clr) begin
            count_r <= 8'd0;
        end else if (inc && (count_r != 8'hFF)) begin
            count_r <= count_r + 8'd1;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/round_controller.sv
// round_controller: initiator side of the counter/game interface.
// Takes one round command over a valid/ready handshake, optionally preloads
// the counter, runs it in the requested mode for a fixed length or until the
// game signals gameover, then returns one result on a valid/ready channel.
//
// Build option: define ROUND_STATS_EN to build the winner/loser pulse
// counters; without it rsp_wins/rsp_losses are constant 0.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_load, cmd_val, cmd_mode,      command fields (preload flag, preload
//   cmd_len                           value, counter mode, length; 0 = open)
//   init, val, ctrl                   counter controls
//   winner, loser                     counter all-ones / all-zeros pulses
//   gameover, who                     game end pulse and side
//   rsp_valid/rsp_ready               response handshake
//   rsp_who, rsp_wins, rsp_losses     response fields
// All outputs decode from registers only.
module round_controller
    import round_pkg::*;
#(
    parameter int N     = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [N-1:0]     cmd_val,
    input  logic [1:0]       cmd_mode,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             init,
    output logic [N-1:0]     val,
    output logic [1:0]       ctrl,
    input  logic             winner,
    input  logic             loser,
    input  logic             gameover,
    input  logic [1:0]       who,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_who,
    output logic [7:0]       rsp_wins,
    output logic [7:0]       rsp_losses
);

    round_state_t     state_r;
    round_state_t     state_s;
    logic [1:0]       mode_r;
    logic [N-1:0]     val_r;
    logic             len_zero_r;
    logic [LEN_W-1:0] remaining_r;
    logic [1:0]       who_r;
    logic             accept_s;
    logic             last_cycle_s;

    assign accept_s     = (state_r == ST_IDLE) && cmd_valid;
    // Fixed-length round ends on the cycle where one cycle is left.
    assign last_cycle_s = !len_zero_r && (remaining_r == LEN_W'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; gameover takes priority over the length timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s = cmd_load ? ST_LOAD : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_RUN;
            end
            ST_RUN: begin
                if (gameover) begin
                    state_s = ST_REPORT;
                end else if (last_cycle_s) begin
                    state_s = ST_REPORT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_REPORT: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REPORT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Round context: command capture, length countdown and result side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r      <= MODE_UP1;
            val_r       <= '0;
            len_zero_r  <= 1'b0;
            remaining_r <= '0;
            who_r       <= WHO_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        mode_r      <= cmd_mode;
                        val_r       <= cmd_val;
                        len_zero_r  <= (cmd_len == '0);
                        remaining_r <= cmd_len;
                        who_r       <= WHO_NONE;
                    end
                end
                ST_RUN: begin
                    if (gameover) begin
                        who_r <= who;
                    end else if (last_cycle_s) begin
                        who_r <= WHO_NONE;
                    end else if (!len_zero_r) begin
                        remaining_r <= remaining_r - LEN_W'(1);
                    end
                end
                default: begin
                    who_r <= who_r;
                end
            endcase
        end
    end

`ifdef ROUND_STATS_EN
    logic [7:0] wins_s;
    logic [7:0] losses_s;

    sat_counter8 u_wins (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_s),
        .inc   ((state_r == ST_RUN) && winner),
        .count (wins_s)
    );

    sat_counter8 u_losses (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_s),
        .inc   ((state_r == ST_RUN) && loser),
        .count (losses_s)
    );

    assign rsp_wins   = wins_s;
    assign rsp_losses = losses_s;
`else
    logic unused_stats_s;
    assign unused_stats_s = winner ^ loser ^ accept_s;
    assign rsp_wins       = 8'd0;
    assign rsp_losses     = 8'd0;
`endif

    assign cmd_ready = (state_r == ST_IDLE);
    assign init      = (state_r == ST_LOAD);
    assign val       = (state_r == ST_LOAD) ? val_r : '0;
    assign ctrl      = (state_r == ST_RUN) ? mode_r : MODE_UP1;
    assign rsp_valid = (state_r == ST_REPORT);
    assign rsp_who   = who_r;

endmodule

// File: tb/tb_round_controller.sv
module tb_round_controller;

`ifdef ROUND_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int EVN = 320;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_load = 1'b0;
    logic [3:0] cmd_val = 4'd0;
    logic [1:0] cmd_mode = 2'd0;
    logic [7:0] cmd_len = 8'd0;
    logic       init;
    logic [3:0] val;
    logic [1:0] ctrl;
    logic       winner = 1'b0;
    logic       loser = 1'b0;
    logic       gameover = 1'b0;
    logic [1:0] who = 2'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [1:0] rsp_who;
    logic [7:0] rsp_wins;
    logic [7:0] rsp_losses;

    int n_checks = 0;
    int n_errors = 0;

    // per-RUN-cycle event script
    logic       ev_w   [0:EVN-1];
    logic       ev_l   [0:EVN-1];
    logic       ev_g   [0:EVN-1];
    logic [1:0] ev_who [0:EVN-1];

    typedef struct {
        logic        ld;
        logic [3:0]  v;
        logic [1:0]  md;
        logic [7:0]  ln;
        logic [15:0] wm;
        logic [15:0] lm;
        int          gpos;
        logic [1:0]  gwho;
        int          rdelay;
        int          er;
        int          ew;
        int          el;
        logic [1:0]  ewho;
    } vec_t;

    vec_t vecs [0:6];

    round_controller #(.N(4), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_load   (cmd_load),
        .cmd_val    (cmd_val),
        .cmd_mode   (cmd_mode),
        .cmd_len    (cmd_len),
        .init       (init),
        .val        (val),
        .ctrl       (ctrl),
        .winner     (winner),
        .loser      (loser),
        .gameover   (gameover),
        .who        (who),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_who    (rsp_who),
        .rsp_wins   (rsp_wins),
        .rsp_losses (rsp_losses)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_events();
        for (int i = 0; i < EVN; i++) begin
            ev_w[i] = 1'b0;
            ev_l[i] = 1'b0;
            ev_g[i] = 1'b0;
            ev_who[i] = 2'd0;
        end
    endtask

    // Reference: walk the event script; the round ends at the first gameover
    // or after len cycles, counting pulses (capped at 255) up to that point.
    task automatic model(input int len, output int r, output int w, output int l,
                         output logic [1:0] wh);
        r = EVN; w = 0; l = 0; wh = 2'd0;
        for (int i = 0; i < EVN; i++) begin
            if (ev_w[i]) w = (w < 255) ? w + 1 : 255;
            if (ev_l[i]) l = (l < 255) ? l + 1 : 255;
            if (ev_g[i]) begin
                r = i + 1; wh = ev_who[i];
                break;
            end
            if (len != 0 && i + 1 == len) begin
                r = len; wh = 2'd0;
                break;
            end
        end
    endtask

    task automatic noise(input bit en);
        if (en) begin
            winner   = 1'($urandom);
            loser    = 1'($urandom);
            gameover = 1'($urandom);
            who      = 2'($urandom);
        end else begin
            winner = 1'b0; loser = 1'b0; gameover = 1'b0; who = 2'd0;
        end
    endtask

    // Runs one round; called and returns at a negedge with the DUT in IDLE.
    task automatic do_round(input logic ld, input logic [3:0] v, input logic [1:0] md,
                            input logic [7:0] ln, input int rdelay, input bit nz,
                            input int er, input int ew, input int el, input logic [1:0] ewho);
        int ew_e;
        int el_e;
        ew_e = STATS ? ew : 0;
        el_e = STATS ? el : 0;
        chk("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_load = ld; cmd_val = v; cmd_mode = md; cmd_len = ln;
        noise(nz);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_load = 1'b0; cmd_val = ~v; cmd_mode = ~md; cmd_len = 8'd1;
        chk("busy_cmd_ready", cmd_ready, 0);
        if (ld) begin
            chk("load_init", init, 1);
            chk("load_val", val, v);
            chk("load_ctrl", ctrl, 0);
            noise(nz);
            @(negedge clk);
        end
        for (int i = 0; i < er; i++) begin
            winner = ev_w[i]; loser = ev_l[i]; gameover = ev_g[i]; who = ev_who[i];
            chk("run_ctrl", ctrl, md);
            chk("run_init", init, 0);
            chk("run_val", val, 0);
            chk("run_rsp_valid", rsp_valid, 0);
            @(negedge clk);
        end
        for (int d = 0; d <= rdelay; d++) begin
            noise(nz);
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_who", rsp_who, ewho);
            chk("rsp_wins", rsp_wins, ew_e);
            chk("rsp_losses", rsp_losses, el_e);
            chk("rpt_cmd_ready", cmd_ready, 0);
            chk("rpt_ctrl", ctrl, 0);
            if (d == rdelay) rsp_ready = 1'b1;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        noise(1'b0);
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        int r, w, l, rd, gp;
        logic [1:0] wh;
        logic [7:0] ln;

        vecs[0] = '{1'b1, 4'd14, 2'd0, 8'd3, 16'h0001, 16'h0002, -1, 2'd0, 0, 3, 1, 1, 2'd0};
        vecs[1] = '{1'b0, 4'd0,  2'd3, 8'd0, 16'h0000, 16'h0000,  6, 2'd2, 1, 7, 0, 0, 2'd2};
        vecs[2] = '{1'b0, 4'd5,  2'd1, 8'd5, 16'h0010, 16'h0003,  4, 2'd1, 0, 5, 1, 2, 2'd1};
        vecs[3] = '{1'b1, 4'd3,  2'd2, 8'd1, 16'h0001, 16'h0001, -1, 2'd0, 4, 1, 1, 1, 2'd0};
        vecs[4] = '{1'b0, 4'd9,  2'd0, 8'd2, 16'h0002, 16'hFFFF,  0, 2'd1, 2, 1, 0, 1, 2'd1};
        vecs[5] = '{1'b1, 4'd15, 2'd1, 8'd4, 16'h00F0, 16'h0008, -1, 2'd0, 0, 4, 0, 1, 2'd0};
        vecs[6] = '{1'b0, 4'd0,  2'd3, 8'd2, 16'h0003, 16'h0000,  1, 2'd2, 0, 2, 2, 0, 2'd2};

        // reset state
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_init", init, 0);
        chk("rst_val", val, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_who", rsp_who, 0);
        chk("rst_rsp_wins", rsp_wins, 0);
        chk("rst_rsp_losses", rsp_losses, 0);
        rst = 1'b0;
        @(negedge clk);

        // table-driven rounds
        for (int k = 0; k < 7; k++) begin
            clear_events();
            for (int i = 0; i < 16; i++) begin
                ev_w[i] = vecs[k].wm[i];
                ev_l[i] = vecs[k].lm[i];
            end
            if (vecs[k].gpos >= 0) begin
                ev_g[vecs[k].gpos] = 1'b1;
                ev_who[vecs[k].gpos] = vecs[k].gwho;
            end
            do_round(vecs[k].ld, vecs[k].v, vecs[k].md, vecs[k].ln, vecs[k].rdelay, 1'b0,
                     vecs[k].er, vecs[k].ew, vecs[k].el, vecs[k].ewho);
        end

        // saturation: open-ended round, winner every cycle for 300 cycles
        clear_events();
        for (int i = 0; i < 300; i++) ev_w[i] = 1'b1;
        ev_l[10] = 1'b1;
        ev_g[299] = 1'b1;
        ev_who[299] = 2'd1;
        do_round(1'b0, 4'd0, 2'd2, 8'd0, 1, 1'b0, 300, 255, 1, 2'd1);

        // reset in the middle of RUN discards the round
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_mode = 2'd3; cmd_len = 8'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        winner = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_ctrl", ctrl, 3);
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_init", init, 0);
        chk("midrst_ctrl", ctrl, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_wins", rsp_wins, 0);
        @(negedge clk);
        rst = 1'b0;
        winner = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("after_rst_rsp_valid", rsp_valid, 0);
            chk("after_rst_cmd_ready", cmd_ready, 1);
        end

        // randomized rounds against the reference model
        for (int k = 0; k < 25; k++) begin
            clear_events();
            ln = 8'($urandom_range(0, 12));
            for (int i = 0; i < 40; i++) begin
                ev_w[i] = ($urandom_range(0, 2) == 0);
                ev_l[i] = ($urandom_range(0, 2) == 0);
            end
            if (ln == 8'd0 || $urandom_range(0, 1) == 1) begin
                gp = (ln == 8'd0) ? $urandom_range(0, 20) : $urandom_range(0, int'(ln) + 2);
                ev_g[gp] = 1'b1;
                ev_who[gp] = 2'($urandom);
            end
            model(int'(ln), r, w, l, wh);
            rd = $urandom_range(0, 3);
            do_round(1'($urandom), 4'($urandom), 2'($urandom), ln, rd, 1'b1, r, w, l, wh);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/round_controller.md
# round_controller

Initiator side of the counter/game interface. Accepts round commands over a valid/ready handshake and drives the counter's `init`, `val` and `ctrl` inputs. It observes the counter's `winner`/`loser` pulses and the game's `gameover`/`who` outputs, then returns one result per round on a valid/ready response channel. It sits between the testbench or system sequencer and the counter, in place of direct stimulus.

## Interface
- `N`, 4: counter width; matches the counter's `n`.
- `LEN_W`, 8: width of the round-length field.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_load`  in  1  preload the counter before the round.
- `cmd_val`  in  N  preload value.
- `cmd_mode`  in  2  counting mode for the round (counter `ctrl` encoding).
- `cmd_len`  in  LEN_W  round length in cycles; 0 = run until `gameover`.
- `init`  out  1  to counter: load request.
- `val`  out  N  to counter: load value.
- `ctrl`  out  2  to counter: mode.
- `winner`  in  1  from counter: all-ones pulse.
- `loser`  in  1  from counter: all-zeros pulse.
- `gameover`  in  1  from game: end-of-game pulse.
- `who`  in  2  from game: 01 = winner side, 10 = loser side.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  result consumed.
- `rsp_who`  out  2  `who` captured at `gameover`; 00 if the round timed out.
- `rsp_wins`  out  8  `winner` pulses seen during the round.
- `rsp_losses`  out  8  `loser` pulses seen during the round.

## Operation
- States: IDLE, LOAD, RUN, REPORT.
- **IDLE**
  - `cmd_ready`=1.
  - On handshake, capture `cmd_*`, clear the pulse counters and load `remaining`=`cmd_len`.
  - Next state is LOAD if `cmd_load`, else RUN.
- **LOAD**
  - One cycle with `init`=1 and `val`=captured value.
  - Next state is RUN.
- **RUN**
  - `ctrl`=captured mode.
  - Each cycle, a `winner` pulse increments `wins` and a `loser` pulse increments `losses`; both counters saturate at 255.
  - If `gameover`=1: capture `who` into `rsp_who` and go to REPORT.
  - Else if `cmd_len`≠0 and `remaining`==1: set `rsp_who`=00 and go to REPORT.
  - Else `remaining` decrements (held when `cmd_len`=0).
- **REPORT**
  - `rsp_valid`=1 and all `rsp_*` held stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE.
- Outside RUN: `ctrl`=00. Outside LOAD: `init`=0 and `val`=0.
- `winner`, `loser` and `gameover` are ignored outside RUN.
- Simultaneous events:
  - `gameover` on the last length cycle: the gameover path wins and `who` is reported.
  - `winner` and `gameover` in the same cycle: the pulse is counted.
- Reset:
  - While asserted: state=IDLE, `remaining`=0, all counters 0.
  - Every output resets to 0 except `cmd_ready`, which is 1 once in IDLE.
  - Mid-round reset discards the round; no response is produced.

## Timing
- All outputs are decoded from registered state and registers; there is no combinational input→output path.
- Command accepted at edge T:
  - With load: `init`=1 during cycle T..T+1, and RUN begins at edge T+1.
  - Without load: RUN begins at edge T.
- A round with `cmd_len`=L spends exactly L cycles in RUN.
- `rsp_valid` rises at the edge following the terminating RUN cycle.
- `cmd_ready` returns the cycle after the response handshake: a minimum of 2 idle-to-idle cycles.

## Configuration
- `ROUND_STATS_EN`
  - Defined: the `wins`/`losses` counters are built and drive `rsp_wins`/`rsp_losses`.
  - Undefined: the counters are not built, and `rsp_wins`/`rsp_losses` are tied to 0.
  - All other behaviour is identical in both builds.

## Structure
- Package `round_pkg` holds:
  - the state enum `round_state_t`;
  - mode constants `MODE_UP1`=00, `MODE_UP2`=01, `MODE_DN1`=10, `MODE_DN2`=11;
  - who constants `WHO_NONE`=00, `WHO_WIN`=01, `WHO_LOSE`=10.
- Sub-module `sat_counter8`: clear plus increment, 8-bit saturating. Instantiated twice, under `ROUND_STATS_EN` only.

## Test plan
- Reset mid-RUN → `rsp_valid` never asserts, `init`=0, `ctrl`=00, `cmd_ready`=1 after reset deasserts.
- `cmd_load`=1, `cmd_val`=14, `cmd_mode`=00, `cmd_len`=3 → one `init` pulse with `val`=14, then 3 RUN cycles; counter goes 15, 0, 1; `rsp_wins`=1, `rsp_losses`=1, `rsp_who`=00.
- `cmd_mode`=11, `cmd_len`=0, game forced to `gameover` with `who`=10 → `rsp_who`=10 one edge later, `rsp_valid` held.
- `cmd_len`=5 with `gameover` and `who`=01 on the 5th RUN cycle → `rsp_who`=01, not 00.
- `rsp_ready` held low for 4 cycles → `rsp_*` stable and `cmd_ready`=0 throughout; a new command is accepted the cycle after `rsp_ready`.
- Build without `ROUND_STATS_EN`, repeat the second scenario → `rsp_wins`=`rsp_losses`=0, all timing identical.
